// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO: registered-read RAM, 2-stage read pipe, 2-entry prefetch.
// Define SYNC_FIFO_FWFT_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module sync_fifo_fwft #(
   parameter int ADDR_WIDTH    = 4,
   parameter int DATA_WIDTH    = 32,
   parameter int AFULL_THRESH  = (2**ADDR_WIDTH) - 2,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  full,
   output logic                  almost_full,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] CNT_ONE    = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH:0] FULL_LVL   = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AFULL_LVL  = (ADDR_WIDTH+1)'(AFULL_THRESH);
   localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH:0]   wr_ptr;
   logic [ADDR_WIDTH:0]   rd_ptr;
   logic [ADDR_WIDTH:0]   count_nxt;
   logic                  push;
   logic                  pop;
   logic                  issue;
   logic                  p0_load;
   logic                  p1_load;
   logic                  p1_move;

   logic                  vld_p0;
   logic [ADDR_WIDTH-1:0] addr_p0;
   logic                  vld_p1;
   logic [DATA_WIDTH-1:0] data_p1;
   logic [1:0]            pf_cnt_p2;
   logic [1:0]            pf_cnt_nxt;
   logic [DATA_WIDTH-1:0] pf_data_p2 [2];

   assign rd_valid = (pf_cnt_p2 != 2'd0);
   assign rd_data  = rd_valid ? pf_data_p2[0] : '0;

   // Ready ripples back from the prefetch buffer so a stalled stage holds its word.
   always_comb begin
      push       = wr_en && !full && !rst;
      pop        = rd_en && rd_valid;
      p1_move    = vld_p1 && ((pf_cnt_p2 != 2'd2) || pop);
      p1_load    = !vld_p1 || p1_move;
      p0_load    = !vld_p0 || p1_load;
      issue      = (rd_ptr != wr_ptr) && p0_load;
      count_nxt  = count;
      pf_cnt_nxt = pf_cnt_p2;
      if (push && !pop)
         count_nxt = count + CNT_ONE;
      else if (pop && !push)
         count_nxt = count - CNT_ONE;
      if (p1_move && !pop)
         pf_cnt_nxt = pf_cnt_p2 + 2'd1;
      else if (pop && !p1_move)
         pf_cnt_nxt = pf_cnt_p2 - 2'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         full         <= 1'b0;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         vld_p0       <= 1'b0;
         vld_p1       <= 1'b0;
         pf_cnt_p2    <= 2'd0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + CNT_ONE;
         if (issue)
            rd_ptr <= rd_ptr + CNT_ONE;
         count        <= count_nxt;
         full         <= (count_nxt == FULL_LVL);
         almost_full  <= (count_nxt >= AFULL_LVL);
         almost_empty <= (count_nxt <= AEMPTY_LVL);
         if (p0_load)
            vld_p0 <= issue;
         if (p1_load)
            vld_p1 <= vld_p0;
         pf_cnt_p2 <= pf_cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
      // p0: registered read address
      if (p0_load)
         addr_p0 <= rd_ptr[ADDR_WIDTH-1:0];
      // p1: registered RAM read data
      if (p1_load)
         data_p1 <= mem[addr_p0];
      // p2: prefetch buffer, entry 0 is the head word
      if (p1_move && ((pf_cnt_p2 == 2'd0) || ((pf_cnt_p2 == 2'd1) && pop)))
         pf_data_p2[0] <= data_p1;
      else if (pop && (pf_cnt_p2 == 2'd2))
         pf_data_p2[0] <= pf_data_p2[1];
      if (p1_move && (((pf_cnt_p2 == 2'd1) && !pop) || (pf_cnt_p2 == 2'd2)))
         pf_data_p2[1] <= data_p1;
   end

`ifdef SYNC_FIFO_FWFT_ERR_FLAGS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en && full)
            overflow <= 1'b1;
         if (rd_en && !rd_valid)
            underflow <= 1'b1;
      end
   end
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Scoreboard bench for sync_fifo_fwft (ADDR_WIDTH=4, DATA_WIDTH=8, default thresholds).
module tb_sync_fifo_fwft;

`ifdef SYNC_FIFO_FWFT_ERR_FLAGS_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       rd_en = 1'b0;
   logic       full, almost_full, rd_valid, almost_empty, overflow, underflow;
   logic [7:0] rd_data;
   logic [4:0] count;

   int checks = 0;
   int passed = 0;
   int m_count = 0;
   logic [7:0] sb[$];

   sync_fifo_fwft #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
      .almost_full(almost_full), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
      .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One clock: drive at negedge, model push/pop, return to posedge+1.
   task automatic cycle(input logic we, input logic [7:0] wd, input logic re,
                        output logic popped, output logic [7:0] got, output logic [7:0] exp);
      logic push_now;
      @(negedge clk);
      popped = re && rd_valid;
      got    = rd_data;
      exp    = 8'hxx;
      if (popped && sb.size() > 0)
         exp = sb.pop_front();
      push_now = we && (m_count < 16);
      if (push_now)
         sb.push_back(wd);
      m_count = m_count + int'(push_now) - int'(popped);
      wr_en = we; wr_data = wd; rd_en = re;
      @(posedge clk); #1;
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   task automatic do_reset(input logic we, input logic re);
      @(negedge clk);
      rst = 1'b1; wr_en = we; wr_data = 8'hEE; rd_en = re;
      @(posedge clk); #1;
      rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      sb.delete();
      m_count = 0;
   endtask

   task automatic test_reset;
      do_reset(1'b0, 1'b0);
      checks++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); else passed++;
      checks++; if (full !== 1'b0) $display("FAIL reset_full: got %b expected 0", full); else passed++;
      checks++; if (almost_full !== 1'b0) $display("FAIL reset_almost_full: got %b expected 0", almost_full); else passed++;
      checks++; if (almost_empty !== 1'b1) $display("FAIL reset_almost_empty: got %b expected 1", almost_empty); else passed++;
      checks++; if (count !== 5'd0) $display("FAIL reset_count: got %0d expected 0", count); else passed++;
      checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else passed++;
      checks++; if (underflow !== 1'b0) $display("FAIL reset_underflow: got %b expected 0", underflow); else passed++;
      checks++; if (rd_data !== 8'h00) $display("FAIL reset_rd_data: got %h expected 00", rd_data); else passed++;
   endtask

   task automatic test_single;
      logic p; logic [7:0] g, e;
      cycle(1'b1, 8'hA5, 1'b0, p, g, e);
      checks++; if (count !== 5'd1) $display("FAIL single_count: got %0d expected 1", count); else passed++;
      for (int i = 1; i <= 2; i++) begin
         cycle(1'b0, 8'h00, 1'b0, p, g, e);
         checks++; if (rd_valid !== 1'b0) $display("FAIL single_early_valid k+%0d: got %b expected 0", i, rd_valid); else passed++;
      end
      cycle(1'b0, 8'h00, 1'b0, p, g, e);
      checks++; if (rd_valid !== 1'b1) $display("FAIL single_valid k+3: got %b expected 1", rd_valid); else passed++;
      checks++; if (rd_data !== 8'hA5) $display("FAIL single_data k+3: got %h expected a5", rd_data); else passed++;
      cycle(1'b0, 8'h00, 1'b0, p, g, e);
      checks++; if (rd_data !== 8'hA5) $display("FAIL single_stable: got %h expected a5", rd_data); else passed++;
      cycle(1'b0, 8'h00, 1'b1, p, g, e);
      checks++; if (!p || g !== e) $display("FAIL single_pop: got %h (popped %b) expected %h", g, p, e); else passed++;
      checks++; if (rd_valid !== 1'b0 || count !== 5'd0) $display("FAIL single_after_pop: got valid %b count %0d expected 0 0", rd_valid, count); else passed++;
   endtask

   task automatic test_fill_overflow;
      logic p; logic [7:0] g, e;
      for (int i = 0; i < 16; i++) begin
         cycle(1'b1, 8'(i), 1'b0, p, g, e);
         checks++; if (count !== 5'(i + 1)) $display("FAIL fill_count %0d: got %0d expected %0d", i, count, i + 1); else passed++;
         checks++; if (almost_full !== (i + 1 >= 14)) $display("FAIL fill_almost_full %0d: got %b expected %b", i, almost_full, (i + 1 >= 14)); else passed++;
         checks++; if (full !== (i + 1 == 16)) $display("FAIL fill_full %0d: got %b expected %b", i, full, (i + 1 == 16)); else passed++;
      end
      cycle(1'b1, 8'h55, 1'b0, p, g, e);
      checks++; if (full !== 1'b1 || count !== 5'd16) $display("FAIL overflow_state: got full %b count %0d expected 1 16", full, count); else passed++;
      checks++; if (overflow !== ERR_EN) $display("FAIL overflow_flag: got %b expected %b", overflow, ERR_EN); else passed++;
   endtask

   task automatic test_drain;
      logic p; logic [7:0] g, e;
      for (int i = 0; i < 16; i++) begin
         cycle(1'b0, 8'h00, 1'b1, p, g, e);
         checks++; if (!p || g !== e || g !== 8'(i)) $display("FAIL drain_word %0d: got %h (popped %b) expected %h", i, g, p, 8'(i)); else passed++;
         checks++; if (count !== 5'(15 - i)) $display("FAIL drain_count %0d: got %0d expected %0d", i, count, 15 - i); else passed++;
         checks++; if (almost_empty !== (15 - i <= 2)) $display("FAIL drain_almost_empty %0d: got %b expected %b", i, almost_empty, (15 - i <= 2)); else passed++;
      end
      checks++; if (rd_valid !== 1'b0 || almost_empty !== 1'b1) $display("FAIL drain_end: got valid %b aempty %b expected 0 1", rd_valid, almost_empty); else passed++;
   endtask

   task automatic test_full_push_pop;
      logic p; logic [7:0] g, e;
      int n;
      for (int i = 0; i < 16; i++)
         cycle(1'b1, 8'(8'h40 + i), 1'b0, p, g, e);
      cycle(1'b1, 8'h77, 1'b1, p, g, e);
      checks++; if (!p || g !== e) $display("FAIL fullpp_pop: got %h (popped %b) expected %h", g, p, e); else passed++;
      checks++; if (count !== 5'd15 || full !== 1'b0) $display("FAIL fullpp_count: got %0d full %b expected 15 0", count, full); else passed++;
      n = 0;
      for (int c = 0; c < 40 && sb.size() > 0; c++) begin
         cycle(1'b0, 8'h00, 1'b1, p, g, e);
         if (p) begin
            n++;
            checks++; if (g !== e) $display("FAIL fullpp_word %0d: got %h expected %h", n, g, e); else passed++;
         end
      end
      checks++; if (n != 15 || count !== 5'd0) $display("FAIL fullpp_drain: got %0d words count %0d expected 15 0", n, count); else passed++;
   endtask

   task automatic test_back_to_back;
      logic p; logic [7:0] g, e;
      logic we;
      int sent, npop;
      sent = 0; npop = 0;
      for (int c = 0; c < 80 && npop < 40; c++) begin
         we = (sent < 40);
         cycle(we, 8'(sent * 3 + 7), 1'b1, p, g, e);
         if (we) sent++;
         if (p) begin
            checks++; if (g !== e) $display("FAIL stream_word %0d: got %h expected %h", npop, g, e); else passed++;
            if (we) begin
               checks++; if (count !== 5'd4) $display("FAIL stream_count %0d: got %0d expected 4", npop, count); else passed++;
            end
            npop++;
         end else if (npop > 0) begin
            checks++; $display("FAIL stream_bubble after %0d words: got no word expected one", npop);
         end
      end
      checks++; if (npop != 40) $display("FAIL stream_total: got %0d expected 40", npop); else passed++;
   endtask

   task automatic test_underflow;
      logic p; logic [7:0] g, e;
      do_reset(1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, p, g, e);
      checks++; if (rd_valid !== 1'b0 || count !== 5'd0) $display("FAIL underflow_state: got valid %b count %0d expected 0 0", rd_valid, count); else passed++;
      checks++; if (underflow !== ERR_EN) $display("FAIL underflow_flag: got %b expected %b", underflow, ERR_EN); else passed++;
      checks++; if (almost_empty !== 1'b1) $display("FAIL underflow_aempty: got %b expected 1", almost_empty); else passed++;
   endtask

   task automatic test_reset_midflight;
      logic p; logic [7:0] g, e;
      do_reset(1'b0, 1'b0);
      for (int i = 0; i < 7; i++)
         cycle(1'b1, 8'(8'h10 + i), 1'b0, p, g, e);
      checks++; if (count !== 5'd7) $display("FAIL midrst_count_before: got %0d expected 7", count); else passed++;
      do_reset(1'b1, 1'b1);
      checks++; if (rd_valid !== 1'b0 || count !== 5'd0 || full !== 1'b0 || almost_full !== 1'b0)
         $display("FAIL midrst_ctrl: got valid %b count %0d full %b afull %b expected 0 0 0 0", rd_valid, count, full, almost_full); else passed++;
      checks++; if (almost_empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0 || rd_data !== 8'h00)
         $display("FAIL midrst_flags: got aempty %b ovf %b unf %b data %h expected 1 0 0 00", almost_empty, overflow, underflow, rd_data); else passed++;
      cycle(1'b1, 8'h3C, 1'b0, p, g, e);
      for (int i = 1; i <= 2; i++) begin
         cycle(1'b0, 8'h00, 1'b0, p, g, e);
         checks++; if (rd_valid !== 1'b0) $display("FAIL midrst_early_valid k+%0d: got %b expected 0", i, rd_valid); else passed++;
      end
      cycle(1'b0, 8'h00, 1'b0, p, g, e);
      checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h3C) $display("FAIL midrst_first_word: got valid %b data %h expected 1 3c", rd_valid, rd_data); else passed++;
      cycle(1'b0, 8'h00, 1'b1, p, g, e);
      checks++; if (!p || g !== e) $display("FAIL midrst_pop: got %h (popped %b) expected %h", g, p, e); else passed++;
   endtask

   initial begin
      test_reset;
      test_single;
      test_fill_overflow;
      test_drain;
      test_full_push_pop;
      test_back_to_back;
      test_underflow;
      test_reset_midflight;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/sync_fifo_fwft.md
SYNC_FIFO_FWFT -- requirements
Module: sync_fifo_fwft

Interface
REQ-001 Parameter ADDR_WIDTH, default 4: log2 of FIFO depth; DEPTH = 2**ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 32: word width in bits.
REQ-003 Parameter AFULL_THRESH, default DEPTH-2: almost_full asserts when count >= AFULL_THRESH.
REQ-004 Parameter AEMPTY_THRESH, default 2: almost_empty asserts when count <= AEMPTY_THRESH.
REQ-005 clk  input  1  sole clock; every port is synchronous to its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 wr_en  input  1  push request.
REQ-008 wr_data  input  DATA_WIDTH  word to push.
REQ-009 full  output  1  count == DEPTH.
REQ-010 almost_full  output  1  count >= AFULL_THRESH.
REQ-011 rd_en  input  1  pop; takes effect only when rd_valid is high.
REQ-012 rd_data  output  DATA_WIDTH  head word, first-word-fall-through.
REQ-013 rd_valid  output  1  rd_data holds the head word.
REQ-014 almost_empty  output  1  count <= AEMPTY_THRESH.
REQ-015 count  output  ADDR_WIDTH+1  words accepted and not yet popped.
REQ-016 overflow, underflow  output  1 each  sticky error flags (see Configuration).

Function
REQ-017 Storage SHALL be a reset-free RAM array with a registered read address and a registered read data output (2-cycle read latency), plus a prefetch stage of at most 2 registered entries feeding rd_data.
REQ-018 Push: wr_en high and full low at an edge writes wr_data at wr_ptr and increments wr_ptr; wr_en high with full high drops the word, leaves pointers and count unchanged.
REQ-019 Pop: rd_en high and rd_valid high at an edge retires the head word; the next word (if any) appears on rd_data by the following edge when already prefetched.
REQ-020 rd_en with rd_valid low SHALL be ignored; FIFO state unchanged.
REQ-021 Pointers are ADDR_WIDTH+1 bits and wrap modulo 2*DEPTH; the RAM is addressed with the low ADDR_WIDTH bits.
REQ-022 count includes words held in the prefetch stage; total capacity is exactly DEPTH words.
REQ-023 Simultaneous accepted push and pop: count unchanged; at full a push is dropped even if a pop occurs on the same edge.
REQ-024 First-word latency: a push into an empty FIFO at edge k SHALL give rd_valid high after edge k+3.
REQ-025 Sustained throughput: with continuous push and continuous pop, once rd_valid is high it SHALL stay high and deliver one word per cycle in FIFO order.
REQ-026 rd_data SHALL remain stable while rd_valid is high and rd_en is low.
REQ-027 full, almost_full, almost_empty and count SHALL be registered and reflect the state after the current edge.

Reset
REQ-028 With rst high at an edge: pointers, count and prefetch stage clear; in-flight RAM reads are discarded.
REQ-029 Output values after reset: rd_valid=0, full=0, almost_full=0, almost_empty=1, count=0, overflow=0, underflow=0, rd_data=0.
REQ-030 RAM contents SHALL NOT be reset; rst has priority over wr_en and rd_en on the same edge.

Configuration
REQ-031 Macro SYNC_FIFO_FWFT_ERR_FLAGS_EN defined: overflow sets on a dropped push, underflow sets on rd_en with rd_valid low; both hold until rst.
REQ-032 Macro SYNC_FIFO_FWFT_ERR_FLAGS_EN undefined: overflow and underflow are tied to 0 and no flag registers are built; all other behaviour is identical.

Verification (ADDR_WIDTH=4, DATA_WIDTH=8, default thresholds)
REQ-033 Single push 0xA5 at edge k into an empty FIFO -> rd_valid=1 and rd_data=0xA5 after edge k+3; count=1 after edge k.
REQ-034 Push 0x00..0x0F with no pops -> full=1 and count=16; almost_full=1 from count=14; 17th push 0x55 is dropped -> overflow=1 (macro on) or 0 (macro off).
REQ-035 From full, pop 16 with rd_en held high -> 0x00..0x0F in order on consecutive cycles, then rd_valid=0, count=0, almost_empty=1.
REQ-036 Continuous push and pop for 40 words (pointer wrap twice) -> output order preserved, no bubbles after the first word, count constant.
REQ-037 rd_en high on an empty FIFO -> no state change, rd_valid stays 0, underflow=1 (macro on).
REQ-038 rst asserted for one edge with count=7 and a read in flight -> all outputs at reset values after that edge; next push 0x3C is output first with 3-cycle latency.
